memory_access: RTL
==================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL take parameter MAX_WAIT, default 15: the maximum number of BUSY cycles spent waiting for dmem_ack before timeout (range 1..255).
REQ-002 The block SHALL use one clock, clk, and a reset, rst; reset is synchronous and active-high.
REQ-003 The block SHALL have the following ports, one per line, as name  direction  width  meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_result  in  32  effective address, or ALU/link result
- rs2E  in  32  store data (forwarded rs2)
- write_regE  in  1  instruction writes the register file
- info_loadE  in  3  0=none, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU; 6 and 7 are treated as none
- info_storeE  in  2  0=none, 1=SB, 2=SH, 3=SW
- dstreg_addrE  in  5  destination register
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  access complete
- stall  out  1  hold upstream stages
- result_M  out  32  value passed to writeback
- write_regM  out  1  writeback enable
- dstreg_addrM  out  5  writeback destination
- forward_data_writemem  out  32  equals result_M, for forwarding
- misalign  out  1  one-cycle pulse on misaligned access
- bus_error  out  1  one-cycle pulse on ack timeout

Function
REQ-004 "access" SHALL mean (info_loadE in 1..5 or info_storeE != 0) with a naturally aligned address: H requires addr[0]=0, W requires addr[1:0]=0. If both a load and a store code are nonzero, the store SHALL take precedence.
REQ-005 The FSM SHALL have states IDLE and BUSY, and SHALL hold a wait counter 8 bits wide.
REQ-006 In IDLE with no access and no misalignment: result_M<=alu_result, write_regM<=write_regE, dstreg_addrM<=dstreg_addrE; latency 1 cycle; stall=0.
REQ-007 In IDLE with an access: latch the address, we, wdata and wstrb; on the next edge dmem_req<=1 and the FSM moves to BUSY; write_regM<=0 (bubble); stall=1 combinationally.
REQ-008 In BUSY, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb SHALL be held stable until dmem_ack or timeout.
REQ-009 In BUSY, stall SHALL equal !dmem_ack while the counter is below MAX_WAIT; stall SHALL be 0 in the terminating cycle.
REQ-010 In BUSY with dmem_ack: dmem_req<=0, the FSM moves to IDLE, and write_regM<=write_regE and dstreg_addrM<=dstreg_addrE; result_M<=the extracted load data for loads, and keeps its previous value for stores.
REQ-011 Load extraction SHALL use lane a=addr[1:0]: LB/LBU take rdata[8a+7:8a], sign- or zero-extended; LH/LHU take rdata[16*a[1]+15:16*a[1]]; LW takes the full 32 bits.
REQ-012 Store encoding SHALL be: SB wdata={4{rs2[7:0]}}, wstrb=4'b0001<<a; SH wdata={2{rs2[15:0]}}, wstrb=4'b0011<<a; SW wdata=rs2, wstrb=4'b1111.
REQ-013 The wait counter SHALL clear on entry to BUSY and increment on each BUSY cycle without ack; when it reaches MAX_WAIT: dmem_req<=0, FSM->IDLE, bus_error pulses for 1 cycle, write_regM<=0, stall=0.
REQ-014 If ack and timeout occur in the same cycle, ack SHALL win and bus_error SHALL stay 0.
REQ-015 On a misaligned load or store in IDLE: no request is issued, misalign pulses for 1 cycle, write_regM<=0, stall=0.
REQ-016 A dmem_ack received in IDLE SHALL be ignored.
REQ-017 forward_data_writemem SHALL be driven combinationally as result_M.

Reset
REQ-018 On rst=1 at a clk edge: FSM=IDLE, counter=0, and every output register = 0 (dmem_*, result_M, write_regM, dstreg_addrM, misalign, bus_error); stall evaluates to 0 unless an access is presented.
REQ-019 Reset while in BUSY SHALL abandon the request: dmem_req=0 on the following cycle, no writeback, no bus_error.

Verification
REQ-020 ALU op: alu_result=0x1234, write_regE=1, dst=5 -> next cycle result_M=0x1234, write_regM=1, dstreg_addrM=5, stall never asserted.
REQ-021 LB at addr 0x103, rdata=0x80FF_FF00, ack after 2 wait cycles -> dmem_addr=0x100, stall high 3 cycles, result_M=0xFFFF_FF80; the same case with LBU -> result_M=0x0000_0080.
REQ-022 SH at addr 0x202, rs2=0xABCD_1234 -> dmem_wdata=0x1234_1234, wstrb=4'b1100, we=1; write_regM=0 after ack.
REQ-023 LW at addr 0x101 -> misalign pulses 1 cycle, dmem_req stays 0, write_regM=0, stall=0.
REQ-024 With MAX_WAIT=3 and ack never asserted -> bus_error pulses once, dmem_req drops, FSM returns to IDLE. Also cover ack arriving exactly at the limit -> a normal completion with no bus_error.
REQ-025 rst asserted during BUSY -> dmem_req=0 on the next cycle and all outputs 0; a subsequent SW proceeds normally.

Source files
------------

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Memory stage of a simple in-order pipeline. ALU results pass straight
// through to writeback. Loads and stores become a single request on a
// req/ack data-memory bus. Stores use lane-replicated data and byte strobes.
// Loaded bytes and halfwords are extracted and sign- or zero-extended.
// A wait counter bounds how long the stage waits for an ack; if the limit
// is reached, the request is dropped and bus_error pulses.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_result               effective address, or ALU/link result
//   rs2E                     store data
//   write_regE, dstreg_addrE writeback enable / destination from execute
//   info_loadE               0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU (6,7 none)
//   info_storeE              0 none, 1 SB, 2 SH, 3 SW (wins over a load code)
//   dmem_req/we/addr/wdata/wstrb  request to data memory, held while BUSY
//   dmem_rdata, dmem_ack     response from data memory
//   stall                    hold upstream stages (combinational)
//   result_M, write_regM, dstreg_addrM  writeback stage inputs
//   forward_data_writemem    copy of result_M for the forwarding network
//   misalign, bus_error      one-cycle event pulses
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] result_M,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM,
  output logic [31:0] forward_data_writemem,
  output logic        misalign,
  output logic        bus_error
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_q;   // byte lane of the outstanding access
  logic [2:0]  load_q;   // load code of the outstanding access

  logic        is_store, is_load, need_half, need_word;
  logic        mem_op, aligned, access, misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic        timeout;

  // Decode the execute-stage instruction and build the store encoding.
  // NOTE: every signal written in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    is_store   = (info_storeE != 2'd0);
    is_load    = !is_store && (info_loadE >= 3'd1) && (info_loadE <= 3'd5);
    need_half  = is_store ? (info_storeE == 2'd2)
                          : (info_loadE == 3'd2) || (info_loadE == 3'd5);
    need_word  = is_store ? (info_storeE == 2'd3) : (info_loadE == 3'd3);
    mem_op     = is_store || is_load;
    aligned    = !((need_word && (alu_result[1:0] != 2'b00)) ||
                   (need_half && alu_result[0]));
    access     = mem_op && aligned;
    misaligned = mem_op && !aligned;

    st_wdata = '0;
    st_wstrb = '0;
    case (info_storeE)
      2'd1: begin
        st_wdata = {4{rs2E[7:0]}};
        st_wstrb = 4'b0001 << alu_result[1:0];
      end
      2'd2: begin
        st_wdata = {2{rs2E[15:0]}};
        st_wstrb = 4'b0011 << alu_result[1:0];
      end
      2'd3: begin
        st_wdata = rs2E;
        st_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    rd_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (load_q)
      3'd1:    load_data = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_data = {24'd0, rd_byte};
      3'd2:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_data = {16'd0, rd_half};
      default: load_data = dmem_rdata;
    endcase
  end

  assign timeout = (wait_cnt >= MAX_WAIT_C);

  // Upstream holds while an access is being launched or waited on. The
  // cycle that ends a BUSY period (ack or timeout) releases the stall so
  // the pipeline advances on the same edge the result is captured.
  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = access;
    else if (!timeout) stall = !dmem_ack;
  end

  assign forward_data_writemem = result_M;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lane_q       <= '0;
      load_q       <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
      result_M     <= '0;
      write_regM   <= 1'b0;
      dstreg_addrM <= '0;
      misalign     <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      misalign  <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= st_wdata;
            dmem_wstrb <= st_wstrb;
            lane_q     <= alu_result[1:0];
            load_q     <= info_loadE;
            wait_cnt   <= '0;
            write_regM <= 1'b0;
            state      <= BUSY;
          end else if (misaligned) begin
            misalign   <= 1'b1;
            write_regM <= 1'b0;
          end else begin
            result_M     <= alu_result;
            write_regM   <= write_regE;
            dstreg_addrM <= dstreg_addrE;
          end
        end
        BUSY: begin
          // An ack in the limit cycle still completes normally.
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            write_regM   <= write_regE;
            dstreg_addrM <= dstreg_addrE;
            if (!dmem_we) result_M <= load_data;
            state        <= IDLE;
          end else if (timeout) begin
            dmem_req   <= 1'b0;
            bus_error  <= 1'b1;
            write_regM <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
